// File: rtl/soc_simple_pll_supervisor_if.sv
// ----------------------------------------------------------------------------
// soc_simple_pll_supervisor_if : PLL control/status and reset-release bundle
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface soc_simple_pll_supervisor_if;
  logic       pll_locked;
  logic       sw_relock_req;
  logic       pll_rst;
  logic       sys_reset_n;
  logic       cpu_reset_n;
  logic       status_locked;
  logic [7:0] relock_count;

  // master: the supervisor, which drives the PLL reset and the system resets
  modport master (
    input  pll_locked, sw_relock_req,
    output pll_rst, sys_reset_n, cpu_reset_n, status_locked, relock_count
  );

  modport slave (
    output pll_locked, sw_relock_req,
    input  pll_rst, sys_reset_n, cpu_reset_n, status_locked, relock_count
  );
endinterface

`default_nettype wire

// File: rtl/soc_simple_pll_supervisor.sv
// ----------------------------------------------------------------------------
// soc_simple_pll_supervisor : PLL reset sequencing, lock supervision and
// staged sys/cpu reset release. Optional macro: PLL_SUP_RELOCK_COUNT_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module soc_simple_pll_supervisor #(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int RELEASE_GAP         = 8,
  parameter int CNT_W               = 17
) (
  input  wire logic                      clk,
  input  wire logic                      reset_n,
  soc_simple_pll_supervisor_if.master    bus
);

  localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_B   = (LOCK_STABLE_CYCLES > RELEASE_GAP) ? LOCK_STABLE_CYCLES : RELEASE_GAP;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;

  if (SYNC_STAGES < 2) begin : g_sync_check
    $error("SYNC_STAGES must be at least 2");
  end
  if ((MAX_CYC >> CNT_W) != 0) begin : g_cnt_w_check
    $error("CNT_W too narrow for the largest cycle parameter");
  end

  localparam logic [2:0] ST_RESET_PLL   = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK   = 3'd1;
  localparam logic [2:0] ST_STABLE      = 3'd2;
  localparam logic [2:0] ST_RELEASE_SYS = 3'd3;
  localparam logic [2:0] ST_RUN         = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] LD_RST     = CNT_W'(PLL_RST_CYCLES - 1);
  // One extra cycle so the system resets assert before pll_rst rises.
  localparam logic [CNT_W-1:0] LD_ABORT   = CNT_W'(PLL_RST_CYCLES);
  localparam logic [CNT_W-1:0] LD_TIMEOUT = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_STABLE  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_GAP     = CNT_W'(RELEASE_GAP - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lk;
  logic [2:0]             state, state_nx;
  logic [CNT_W-1:0]       cnt, cnt_nx;
  logic                   relock_now, event_inc;
  logic                   pll_rst_q, sys_reset_n_q, cpu_reset_n_q, status_q;
  logic                   pll_rst_nx, sys_reset_n_nx, cpu_reset_n_nx, status_nx;

  always_ff @(posedge clk) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
  end
  assign lk = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= ST_RESET_PLL;
      cnt           <= LD_RST;
      pll_rst_q     <= 1'b1;
      sys_reset_n_q <= 1'b0;
      cpu_reset_n_q <= 1'b0;
      status_q      <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      pll_rst_q     <= pll_rst_nx;
      sys_reset_n_q <= sys_reset_n_nx;
      cpu_reset_n_q <= cpu_reset_n_nx;
      status_q      <= status_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt - CNT_ONE;
    relock_now = 1'b0;
    event_inc  = 1'b0;
    case (state)
      ST_RESET_PLL: begin
        if (cnt == '0) begin
          state_nx = ST_WAIT_LOCK;
          cnt_nx   = LD_TIMEOUT;
        end
      end
      ST_WAIT_LOCK: begin
        if (bus.sw_relock_req) begin
          relock_now = 1'b1;
        end else if (lk) begin
          state_nx = ST_STABLE;
          cnt_nx   = LD_STABLE;
        end else if (cnt == '0) begin
          state_nx  = ST_RESET_PLL;
          cnt_nx    = LD_RST;
          event_inc = 1'b1;
        end
      end
      ST_STABLE: begin
        if (!lk) begin
          state_nx = ST_WAIT_LOCK;
          cnt_nx   = LD_TIMEOUT;
        end else if (bus.sw_relock_req) begin
          relock_now = 1'b1;
        end else if (cnt == '0) begin
          state_nx = ST_RELEASE_SYS;
          cnt_nx   = LD_GAP;
        end
      end
      ST_RELEASE_SYS, ST_RUN: begin
        if (state == ST_RUN) cnt_nx = cnt;
        if (!lk) begin
          relock_now = 1'b1;
          event_inc  = 1'b1;
        end else if (bus.sw_relock_req) begin
          relock_now = 1'b1;
        end else if (state == ST_RELEASE_SYS && cnt == '0) begin
          state_nx = ST_RUN;
          cnt_nx   = cnt;
        end
      end
      default: begin
        state_nx = ST_RESET_PLL;
        cnt_nx   = LD_RST;
      end
    endcase
    if (relock_now) begin
      state_nx = ST_RESET_PLL;
      cnt_nx   = LD_ABORT;
    end
  end

  always_comb begin
    pll_rst_nx     = (state_nx == ST_RESET_PLL) && !relock_now;
    sys_reset_n_nx = (state_nx == ST_RELEASE_SYS) || (state_nx == ST_RUN);
    cpu_reset_n_nx = (state_nx == ST_RUN);
    status_nx      = (state_nx == ST_RUN);
  end

  assign bus.pll_rst       = pll_rst_q;
  assign bus.sys_reset_n   = sys_reset_n_q;
  assign bus.cpu_reset_n   = cpu_reset_n_q;
  assign bus.status_locked = status_q;

`ifdef PLL_SUP_RELOCK_COUNT_EN
  logic [7:0] relock_q;
  always_ff @(posedge clk) begin
    if (!reset_n)                            relock_q <= 8'd0;
    else if (event_inc && relock_q != 8'hFF) relock_q <= relock_q + 8'd1;
  end
  assign bus.relock_count = relock_q;
`else
  logic unused_event_inc;
  assign unused_event_inc = event_inc;
  assign bus.relock_count = 8'd0;
`endif

endmodule

`default_nettype wire
